// File: rtl/control_unit_if.sv
// Handshake/bus bundle between the control unit (master) and the datapath/memory side (slave).
interface control_unit_if #(
  parameter int ALU_OPW = 4
) ();
  logic [15:0]        instr;
  logic               zero_flag, sign_flag, carry_flag, mem_ready;
  logic               mem_rd, mem_wr, addr_src, pc_inc, pc_load, ir_load, alu_en;
  logic [ALU_OPW-1:0] alu_op;
  logic [1:0]         bus_src;
  logic               reg_we, halted, fault;
  logic [2:0]         state;

  modport master (
    input  instr, zero_flag, sign_flag, carry_flag, mem_ready,
    output mem_rd, mem_wr, addr_src, pc_inc, pc_load, ir_load, alu_en,
           alu_op, bus_src, reg_we, halted, fault, state
  );

  modport slave (
    output instr, zero_flag, sign_flag, carry_flag, mem_ready,
    input  mem_rd, mem_wr, addr_src, pc_inc, pc_load, ir_load, alu_en,
           alu_op, bus_src, reg_we, halted, fault, state
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit CPU datapath.
// Strobes decode combinationally from the registered state; memory accesses time out into FAULT.
module control_unit #(
  parameter int OPW        = 4,
  parameter int ALU_OPW    = 4,
  parameter int WAIT_LIMIT = 15
) (
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master cu
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;
  localparam int WCW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  logic [2:0]     state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [OPW-1:0] opc;
  logic           mem_timeout;
  logic           unused_instr;

  assign opc          = cu.instr[15 -: OPW];
  assign unused_instr = ^cu.instr[15-OPW:0];
  // A ready in the limit cycle still completes the access.
  assign mem_timeout  = !cu.mem_ready && (wait_cnt_q == WCW'(WAIT_LIMIT));
  assign cu.state     = state_q;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    cu.mem_rd   = 1'b0;
    cu.mem_wr   = 1'b0;
    cu.addr_src = 1'b0;
    cu.pc_inc   = 1'b0;
    cu.pc_load  = 1'b0;
    cu.ir_load  = 1'b0;
    cu.alu_en   = 1'b0;
    cu.alu_op   = '0;
    cu.bus_src  = 2'd0;
    cu.reg_we   = 1'b0;
    cu.halted   = 1'b0;
    cu.fault    = 1'b0;
    case (state_q)
      S_FETCH: begin
        cu.mem_rd  = 1'b1;
        cu.bus_src = 2'd1;
        if (cu.mem_ready) begin
          cu.ir_load = 1'b1;
          cu.pc_inc  = 1'b1;
          state_d    = S_DECODE;
        end else if (mem_timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        case (opc)
          4'h0: ;
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            cu.alu_en = 1'b1;
            cu.alu_op = ALU_OPW'(opc);
            state_d   = S_WB;
          end
          4'h8, 4'h9: state_d = S_MEM;
          4'hA: begin
            cu.bus_src = 2'd3;
            cu.reg_we  = 1'b1;
          end
          4'hB, 4'hC, 4'hD, 4'hE: begin
            cu.bus_src = 2'd3;
            cu.pc_load = (opc == 4'hB) || (opc == 4'hC && cu.zero_flag) ||
                         (opc == 4'hD && cu.sign_flag) || (opc == 4'hE && cu.carry_flag);
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        cu.addr_src = 1'b1;
        if (opc == 4'h8) begin
          cu.mem_rd  = 1'b1;
          cu.bus_src = 2'd1;
          cu.reg_we  = cu.mem_ready;
        end else begin
          cu.mem_wr = 1'b1;
        end
        if (cu.mem_ready)    state_d = S_FETCH;
        else if (mem_timeout) state_d = S_FAULT;
      end
      S_WB: begin
        cu.alu_en  = 1'b1;
        cu.alu_op  = ALU_OPW'(opc);
        cu.bus_src = 2'd2;
        cu.reg_we  = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  cu.halted = 1'b1;
      S_FAULT: cu.fault  = 1'b1;
      default: state_d = S_FAULT;
    endcase

    if (state_d != state_q)
      wait_cnt_d = '0;
    else if ((state_q == S_FETCH || state_q == S_MEM) && !cu.mem_ready)
      wait_cnt_d = wait_cnt_q + 1'b1;

    // Reset overrides every strobe so a held reset never disturbs the datapath.
    if (!reset) begin
      cu.mem_rd   = 1'b0;
      cu.mem_wr   = 1'b0;
      cu.addr_src = 1'b0;
      cu.pc_inc   = 1'b0;
      cu.pc_load  = 1'b0;
      cu.ir_load  = 1'b0;
      cu.alu_en   = 1'b0;
      cu.alu_op   = '0;
      cu.bus_src  = 2'd0;
      cu.reg_we   = 1'b0;
      cu.halted   = 1'b0;
      cu.fault    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
endmodule
